// File: rtl/result_fifo.sv
// result_fifo: 8x32 synchronous FIFO with registered read data, occupancy count and per-request ack/error pulses
//   clk, reset (async active-high) | wr_en, din -> write port | rd_en -> read port
//   dout: registered read data | data_count, full, empty: live occupancy
//   wr_ack/wr_err, rd_ack/rd_err: one-cycle outcome of the previous cycle's request
module result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic                  wr_ok, rd_ok;
  // acceptance uses the count held before the edge, so an empty FIFO never reads the word written on the same edge
  assign wr_ok  = wr_en && cnt_q != DEPTH_C;
  assign rd_ok  = rd_en && cnt_q != '0;
  assign wp_d   = wr_ok ? wp_q + 1'b1 : wp_q;
  assign rp_d   = rd_ok ? rp_q + 1'b1 : rp_q;
  assign dout_d = rd_ok ? mem_q[rp_q] : dout_q;
  assign cnt_d  = (wr_ok && !rd_ok) ? cnt_q + 1'b1 :
                  (rd_ok && !wr_ok) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (wr_ok) mem_q[wp_q] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ok;
      wr_err_q <= wr_en && !wr_ok;
      rd_ack_q <= rd_ok;
      rd_err_q <= rd_en && !rd_ok;
    end
  assign dout       = dout_q;
  assign data_count = cnt_q;
  assign full       = cnt_q == DEPTH_C;
  assign empty      = cnt_q == '0;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: queue-model checker for result_fifo with directed and random stimulus
module tb_result_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mq[$];
  logic [31:0] m_dout = '0;
  logic        m_wa = 1'b0, m_we = 1'b0, m_ra = 1'b0, m_re = 1'b0;

  result_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .data_count(data_count), .full(full), .empty(empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  task automatic compare();
    chk("dout", dout, m_dout);
    chk("data_count", 32'(data_count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 8));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("wr_ack", 32'(wr_ack), 32'(m_wa));
    chk("wr_err", 32'(wr_err), 32'(m_we));
    chk("rd_ack", 32'(rd_ack), 32'(m_ra));
    chk("rd_err", 32'(rd_err), 32'(m_re));
  endtask

  task automatic cycle(input logic we, input logic [31:0] d, input logic re);
    int  n;
    bit  w, r;
    wr_en = we;
    din   = d;
    rd_en = re;
    @(posedge clk);
    n = mq.size();
    w = we && n < 8;
    r = re && n > 0;
    m_wa = w;
    m_we = we && !w;
    m_ra = r;
    m_re = re && !r;
    if (r) m_dout = mq.pop_front();
    if (w) mq.push_back(d);
    @(negedge clk);
    compare();
  endtask

  task automatic reset_mid();
    #2 reset = 1'b1;
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_count", 32'(data_count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
    mq.delete();
    m_dout = '0;
    {m_wa, m_we, m_ra, m_re} = '0;
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  task automatic drain();
    while (mq.size() > 0) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    compare();
    chk("init_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'h11 * i, 1'b0);
      chk("fill_count", 32'(data_count), 32'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 32'h99, 1'b0);
    chk("ovf_err", 32'(wr_err), 32'd1);
    chk("ovf_count", 32'(data_count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("rd_data", dout, 32'h11 * i);
      chk("rd_ack_lit", 32'(rd_ack), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, '0, 1'b1);
    chk("udf_err", 32'(rd_err), 32'd1);
    chk("udf_hold", dout, 32'h88);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'hA0 + i, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("wrap_data", dout, 32'hA0 + i);
    end
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
    cycle(1'b1, 32'd5, 1'b1);
    chk("sim4_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b1010);
    chk("sim4_count", 32'(data_count), 32'd4);
    chk("sim4_dout", dout, 32'd1);
    drain();
    cycle(1'b1, 32'd7, 1'b1);
    chk("sim0_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b1001);
    chk("sim0_count", 32'(data_count), 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b1);
    chk("sim8_flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b0110);
    chk("sim8_count", 32'(data_count), 32'd7);
    chk("sim8_dout", dout, 32'd7);
    drain();
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    reset_mid();
    cycle(1'b1, 32'hCAFE, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_data", dout, 32'hCAFE);
    for (int i = 0; i < 2000; i++) begin
      int wp, rp;
      wp = (i / 200) % 3 == 0 ? 80 : (i / 200) % 3 == 1 ? 20 : 50;
      rp = 100 - wp;
      cycle($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
      if (i == 1000) reset_mid();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_fifo.md
# result_fifo

Eight-entry, 32-bit synchronous FIFO that buffers multiplier results between the result-producing datapath and the output-stage logic. The output stage drives `fifo_we`/`fifo_re` onto `wr_en`/`rd_en` and decides when to drain from the `data_count` this block reports. The block provides registered read data, a live occupancy count, full/empty flags, and per-request acknowledge and error pulses.

## Interface
- `DATA_WIDTH`, 32, width of each stored word.
- `ADDR_WIDTH`, 3, pointer width; depth = 2^ADDR_WIDTH = 8.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write request, sampled at the rising edge.
- `din`  in  DATA_WIDTH  write data, sampled with `wr_en`.
- `rd_en`  in  1  read request, sampled at the rising edge.
- `dout`  out  DATA_WIDTH  registered read data; holds its value between reads.
- `data_count`  out  ADDR_WIDTH+1  current occupancy, 0..8.
- `full`  out  1  high when `data_count` is 8.
- `empty`  out  1  high when `data_count` is 0.
- `wr_ack`  out  1  one-cycle pulse: the write in the previous cycle was accepted.
- `wr_err`  out  1  one-cycle pulse: the write in the previous cycle was rejected because the FIFO was full.
- `rd_ack`  out  1  one-cycle pulse: the read in the previous cycle was accepted; `dout` is valid.
- `rd_err`  out  1  one-cycle pulse: the read in the previous cycle was rejected because the FIFO was empty.

## Operation
- Storage: 8 x DATA_WIDTH register array.
  - 3-bit write pointer `wp` and 3-bit read pointer `rp`, both wrapping 7 -> 0 naturally.
  - Separate 4-bit occupancy counter; full and empty come from the counter, not from pointer comparison.
- Acceptance uses the count held before the edge:
  - A write is valid when `wr_en` is high and the count is below 8.
  - A read is valid when `rd_en` is high and the count is above 0.
- Valid write: `mem[wp] <= din`, `wp <= wp+1`, `wr_ack <= 1`.
- Invalid write: no storage or pointer change, `wr_err <= 1`.
- Valid read: `dout <= mem[rp]`, `rp <= rp+1`, `rd_ack <= 1`.
- Invalid read: `dout` unchanged, `rd_err <= 1`.
- Count update: write only +1; read only -1; both or neither, unchanged.
- Simultaneous read and write:
  - Count 1..7: both accepted, count unchanged.
  - Empty: write accepted, read rejected (`rd_err`), count becomes 1. There is no fall-through; the written word is not returned on the same edge.
  - Full: read accepted, write rejected (`wr_err`), count becomes 7.
- Ack and error outputs are mutually exclusive per port.
  - They are high for exactly one cycle per request, then clear to 0 when there is no request.
  - Back-to-back requests produce continuous pulses.
- Reset (asynchronous, any time including mid-burst):
  - Clears `wp`, `rp`, the count, `dout` (0), and all ack and error outputs (0).
  - Memory contents need not be cleared.
  - After reset, `empty` = 1 and `full` = 0.
  - Data present before reset is lost; the first read after reset returns the first word written after reset.

## Timing
- Write latency: the word written at edge N is readable by a request sampled at edge N+1; `dout` shows it after edge N+1.
- `data_count`, `full` and `empty` reflect edge N's operation immediately after edge N.
  - They are registered count plus combinational decode, with no extra pipeline stage.
- `wr_ack`, `wr_err`, `rd_ack` and `rd_err` are registered; they are valid in the cycle after the sampled request.
- Reset assertion clears the outputs without waiting for `clk`. Deassertion is assumed synchronous to `clk` upstream.

## Test plan
- Reset, then 8 writes of 0x11..0x88 on consecutive cycles:
  - `data_count` steps 1..8 and `full` = 1 after the 8th write.
  - A 9th write of 0x99 gives `wr_err` = 1, the count stays 8, and 0x99 is never read back.
- From full, 8 consecutive reads:
  - `dout` shows 0x11..0x88 in order with `rd_ack` on each read, and `empty` = 1 at the end.
  - A 9th read gives `rd_err` = 1 with `dout` holding 0x88.
- Wrap-around: write 5, read 5, then write 0xA0..0xA5 and read all of them.
  - Data returns in order across the 7 -> 0 pointer wrap.
- Simultaneous requests, each with `wr_en` = `rd_en` = 1 for one cycle:
  - Count 4: `wr_ack` and `rd_ack` both pulse, the count stays 4, and `dout` = the oldest word.
  - Empty: `wr_ack` and `rd_err` pulse, and the count becomes 1.
  - Full: `rd_ack` and `wr_err` pulse, and the count becomes 7.
- Reset mid-operation: with count 5, assert `reset` between clock edges.
  - `data_count` = 0, `empty` = 1, `dout` = 0, and all ack and error outputs are 0 before the next edge.
  - After release, writing 0xCAFE then reading returns 0xCAFE.
